// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - chroni/CPU request and memory signal bundle for bus_arbiter
interface bus_arbiter_if #(
  parameter int ADDR_W     = 16,
  parameter int VID_ADDR_W = 14,
  parameter int DATA_W     = 8
);
  logic                  vid_rd_req;
  logic [VID_ADDR_W-1:0] vid_addr;
  logic                  vid_dma_req;
  logic                  vid_rd_ack;
  logic                  cpu_rd_req;
  logic                  cpu_wr_req;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [DATA_W-1:0]     cpu_wr_data;
  logic                  cpu_ack;
  logic [DATA_W-1:0]     rd_data;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wr_data;
  logic                  mem_wr_en;
  logic [DATA_W-1:0]     mem_rd_data;
  logic                  busy;
  logic                  grant_vid;

  // Requesters and memory side.
  modport master (
    output vid_rd_req, vid_addr, vid_dma_req, cpu_rd_req, cpu_wr_req,
           cpu_addr, cpu_wr_data, mem_rd_data,
    input  vid_rd_ack, cpu_ack, rd_data, mem_addr, mem_wr_data, mem_wr_en,
           busy, grant_vid
  );

  // Arbiter side.
  modport slave (
    input  vid_rd_req, vid_addr, vid_dma_req, cpu_rd_req, cpu_wr_req,
           cpu_addr, cpu_wr_data, mem_rd_data,
    output vid_rd_ack, cpu_ack, rd_data, mem_addr, mem_wr_data, mem_wr_en,
           busy, grant_vid
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - chroni/CPU shared-memory arbiter and access sequencer
// Grants one requester per IDLE->ACCESS->DONE pass; chroni has priority, CPU protected from starvation.
module bus_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int VID_ADDR_W   = 14,
  parameter int DATA_W       = 8,
  parameter int MEM_LATENCY  = 1,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic         sys_clk,
  input  logic         reset_n,
  bus_arbiter_if.slave bus
);
  localparam int LAT_W  = $clog2(MEM_LATENCY + 1);
  localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(MEM_LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic              grant_vid_q, grant_vid_d;
  logic              dma_lock_q, dma_lock_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              cpu_pend, cpu_ok, grant_cpu, grant_chr;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rd_data_q     <= '0;
      mem_wr_en_q   <= 1'b0;
      grant_vid_q   <= 1'b0;
      dma_lock_q    <= 1'b0;
      wait_cnt_q    <= '0;
      lat_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_data_q     <= rd_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
      grant_vid_q   <= grant_vid_d;
      dma_lock_q    <= dma_lock_d;
      wait_cnt_q    <= wait_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rd_data_d     = rd_data_q;
    mem_wr_en_d   = 1'b0;
    grant_vid_d   = grant_vid_q;
    dma_lock_d    = dma_lock_q;
    wait_cnt_d    = wait_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    cpu_pend      = bus.cpu_rd_req | bus.cpu_wr_req;
    cpu_ok        = cpu_pend && !dma_lock_q;
    grant_cpu     = 1'b0;
    grant_chr     = 1'b0;

    case (state_q)
      IDLE: begin
        dma_lock_d = bus.vid_dma_req;
        if (cpu_ok && wait_cnt_q == WAIT_MAX) grant_cpu = 1'b1;
        else if (bus.vid_rd_req)              grant_chr = 1'b1;
        else if (cpu_ok)                      grant_cpu = 1'b1;

        // The DMA lock freezes the starvation count entirely.
        if (!cpu_pend && !dma_lock_q) wait_cnt_d = '0;

        if (grant_cpu) begin
          mem_addr_d  = bus.cpu_addr;
          grant_vid_d = 1'b0;
          wait_cnt_d  = '0;
          if (bus.cpu_wr_req) begin
            mem_wr_data_d = bus.cpu_wr_data;
            mem_wr_en_d   = 1'b1;
          end
        end else if (grant_chr) begin
          mem_addr_d  = ADDR_W'(bus.vid_addr[VID_ADDR_W-1:0]);
          grant_vid_d = 1'b1;
          if (cpu_ok && wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (grant_cpu || grant_chr) begin
          lat_cnt_d = LAT_W'(1);
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt_q == LAT_LAST) begin
          rd_data_d = bus.mem_rd_data;
          state_d   = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.vid_rd_ack  = (state_q == DONE) && grant_vid_q;
  assign bus.cpu_ack     = (state_q == DONE) && !grant_vid_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.grant_vid   = grant_vid_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
  logic sys_clk;
  logic reset_n;
  int   checks;
  int   errors;

  bus_arbiter_if #(.ADDR_W(16), .VID_ADDR_W(14), .DATA_W(8)) bus ();

  bus_arbiter #(
    .ADDR_W(16), .VID_ADDR_W(14), .DATA_W(8), .MEM_LATENCY(1), .CPU_MAX_WAIT(4)
  ) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.vid_rd_req  = 1'b0;
    bus.vid_addr    = '0;
    bus.vid_dma_req = 1'b0;
    bus.cpu_rd_req  = 1'b0;
    bus.cpu_wr_req  = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_wr_data = '0;
    bus.mem_rd_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b1;
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.vid_rd_ack !== 1'b0) begin errors++; $display("FAIL reset_vid_ack: got %b want 0", bus.vid_rd_ack); end
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack: got %b want 0", bus.cpu_ack); end
    checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.mem_wr_en); end
    checks++; if (bus.grant_vid !== 1'b0) begin errors++; $display("FAIL reset_grant_vid: got %b want 0", bus.grant_vid); end
    checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr); end
    checks++; if (bus.mem_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", bus.mem_wr_data); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
    step();
    reset_n = 1'b1;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_cpu_read();
    do_reset();
    bus.cpu_rd_req  = 1'b1;
    bus.cpu_addr    = 16'h1234;
    bus.mem_rd_data = 8'hA5;
    step();
    checks++; if (bus.mem_addr !== 16'h1234) begin errors++; $display("FAIL rd_mem_addr_c1: got %h want 1234", bus.mem_addr); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rd_busy_c1: got %b want 1", bus.busy); end
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_c1: got %b want 0", bus.cpu_ack); end
    checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL rd_wr_en_c1: got %b want 0", bus.mem_wr_en); end
    step();
    checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack_c2: got %b want 1", bus.cpu_ack); end
    checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL rd_data_c2: got %h want a5", bus.rd_data); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rd_busy_c2: got %b want 1", bus.busy); end
    checks++; if (bus.vid_rd_ack !== 1'b0) begin errors++; $display("FAIL rd_vid_ack_c2: got %b want 0", bus.vid_rd_ack); end
    bus.cpu_rd_req  = 1'b0;
    bus.mem_rd_data = 8'h00;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rd_busy_c3: got %b want 0", bus.busy); end
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_c3: got %b want 0", bus.cpu_ack); end
    checks++; if (bus.mem_addr !== 16'h1234) begin errors++; $display("FAIL rd_addr_hold: got %h want 1234", bus.mem_addr); end
    checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL rd_data_hold: got %h want a5", bus.rd_data); end
  endtask

  task automatic test_priority();
    logic va, ca;
    do_reset();
    bus.vid_rd_req  = 1'b1;
    bus.vid_addr    = 14'h2001;
    bus.cpu_rd_req  = 1'b1;
    bus.cpu_addr    = 16'hBEEF;
    bus.mem_rd_data = 8'h11;
    for (int c = 1; c <= 7; c++) begin
      step();
      va = bus.vid_rd_ack;
      ca = bus.cpu_ack;
      checks++; if (va !== (c == 2)) begin errors++; $display("FAIL prio_vid_ack c%0d: got %b want %b", c, va, (c == 2)); end
      checks++; if (ca !== (c == 5)) begin errors++; $display("FAIL prio_cpu_ack c%0d: got %b want %b", c, ca, (c == 5)); end
      if (c == 1) begin
        checks++; if (bus.mem_addr !== 16'h2001) begin errors++; $display("FAIL prio_vid_addr: got %h want 2001", bus.mem_addr); end
        checks++; if (bus.grant_vid !== 1'b1) begin errors++; $display("FAIL prio_grant_vid: got %b want 1", bus.grant_vid); end
      end
      if (c == 4) begin
        checks++; if (bus.mem_addr !== 16'hBEEF) begin errors++; $display("FAIL prio_cpu_addr: got %h want beef", bus.mem_addr); end
        checks++; if (bus.grant_vid !== 1'b0) begin errors++; $display("FAIL prio_grant_cpu: got %b want 0", bus.grant_vid); end
      end
      if (va) bus.vid_rd_req = 1'b0;
      if (ca) bus.cpu_rd_req = 1'b0;
    end
  endtask

  task automatic test_dma_lock();
    int vid_acks, cpu_acks, budget, after, cpu_pos;
    logic gap;
    do_reset();
    bus.vid_dma_req = 1'b1;
    step();
    bus.vid_rd_req = 1'b1;
    bus.vid_addr   = 14'h0010;
    bus.cpu_rd_req = 1'b1;
    bus.cpu_addr   = 16'h4000;
    vid_acks = 0; cpu_acks = 0; budget = 400; gap = 1'b0;
    while (vid_acks < 20 && budget > 0) begin
      step();
      budget--;
      if (bus.cpu_ack) cpu_acks++;
      if (bus.vid_rd_ack) begin
        vid_acks++;
        bus.vid_rd_req = 1'b0;
        gap = 1'b1;
        if (vid_acks == 20) bus.vid_dma_req = 1'b0;
      end else if (gap) gap = 1'b0;
      else bus.vid_rd_req = 1'b1;
    end
    checks++; if (vid_acks !== 20) begin errors++; $display("FAIL dma_vid_transfers: got %0d want 20", vid_acks); end
    checks++; if (cpu_acks !== 0) begin errors++; $display("FAIL dma_cpu_locked: got %0d cpu acks want 0", cpu_acks); end
    after = 0; cpu_pos = 0; budget = 100;
    while (cpu_pos == 0 && after < 3 && budget > 0) begin
      step();
      budget--;
      if (bus.vid_rd_ack || bus.cpu_ack) after++;
      if (bus.cpu_ack) begin
        cpu_pos = after;
        bus.cpu_rd_req = 1'b0;
      end
      if (bus.vid_rd_ack) begin
        bus.vid_rd_req = 1'b0;
        gap = 1'b1;
      end else if (gap) gap = 1'b0;
      else bus.vid_rd_req = 1'b1;
    end
    checks++; if (cpu_pos < 1 || cpu_pos > 2) begin errors++; $display("FAIL dma_release_cpu: cpu ack at transfer %0d want 1..2", cpu_pos); end
    bus.vid_rd_req = 1'b0;
    bus.cpu_rd_req = 1'b0;
  endtask

  task automatic test_starvation();
    int n, budget;
    logic is_cpu;
    do_reset();
    bus.vid_rd_req = 1'b1;
    bus.vid_addr   = 14'h0200;
    bus.cpu_rd_req = 1'b1;
    bus.cpu_addr   = 16'h8000;
    n = 0; budget = 200;
    while (n < 10 && budget > 0) begin
      step();
      budget--;
      if (bus.vid_rd_ack && bus.cpu_ack) begin
        errors++; checks++;
        $display("FAIL starve_overlap: both acks high at transfer %0d", n);
      end
      if (bus.vid_rd_ack || bus.cpu_ack) begin
        is_cpu = bus.cpu_ack;
        checks++; if (is_cpu !== (n % 5 == 4)) begin errors++; $display("FAIL starve_order #%0d: cpu=%b want %b", n, is_cpu, (n % 5 == 4)); end
        n++;
      end
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL starve_count: got %0d transfers want 10", n); end
    bus.vid_rd_req = 1'b0;
    bus.cpu_rd_req = 1'b0;
  endtask

  task automatic test_write();
    int wr_cycles;
    do_reset();
    bus.cpu_wr_req  = 1'b1;
    bus.cpu_rd_req  = 1'b1;
    bus.cpu_addr    = 16'h0042;
    bus.cpu_wr_data = 8'h3C;
    bus.mem_rd_data = 8'h77;
    wr_cycles = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (bus.mem_wr_en) wr_cycles++;
      if (c == 1) begin
        checks++; if (bus.mem_wr_en !== 1'b1) begin errors++; $display("FAIL wr_en_c1: got %b want 1", bus.mem_wr_en); end
        checks++; if (bus.mem_addr !== 16'h0042) begin errors++; $display("FAIL wr_addr: got %h want 0042", bus.mem_addr); end
        checks++; if (bus.mem_wr_data !== 8'h3C) begin errors++; $display("FAIL wr_data: got %h want 3c", bus.mem_wr_data); end
      end
      if (c == 2) begin
        checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack_c2: got %b want 1", bus.cpu_ack); end
        checks++; if (bus.rd_data !== 8'h77) begin errors++; $display("FAIL wr_rd_capture: got %h want 77", bus.rd_data); end
        bus.cpu_wr_req = 1'b0;
        bus.cpu_rd_req = 1'b0;
      end
    end
    checks++; if (wr_cycles !== 1) begin errors++; $display("FAIL wr_strobe_len: got %0d cycles want 1", wr_cycles); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.cpu_wr_req  = 1'b1;
    bus.cpu_addr    = 16'h0099;
    bus.cpu_wr_data = 8'h5A;
    step();
    checks++; if (bus.busy !== 1'b1 || bus.mem_wr_en !== 1'b1) begin errors++; $display("FAIL abort_pre: busy=%b wr_en=%b want 1 1", bus.busy, bus.mem_wr_en); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL abort_wr_en: got %b want 0", bus.mem_wr_en); end
    checks++; if (bus.cpu_ack !== 1'b0 || bus.vid_rd_ack !== 1'b0) begin errors++; $display("FAIL abort_acks: cpu=%b vid=%b want 0 0", bus.cpu_ack, bus.vid_rd_ack); end
    checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL abort_addr: got %h want 0000", bus.mem_addr); end
    bus.cpu_wr_req = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (bus.cpu_ack !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_no_ack c%0d: ack=%b busy=%b want 0 0", c, bus.cpu_ack, bus.busy); end
    end
    bus.vid_rd_req  = 1'b1;
    bus.vid_addr    = 14'h0123;
    bus.mem_rd_data = 8'hC3;
    step();
    checks++; if (bus.mem_addr !== 16'h0123 || bus.grant_vid !== 1'b1) begin errors++; $display("FAIL resume_grant: addr=%h gv=%b want 0123 1", bus.mem_addr, bus.grant_vid); end
    step();
    checks++; if (bus.vid_rd_ack !== 1'b1) begin errors++; $display("FAIL resume_ack: got %b want 1", bus.vid_rd_ack); end
    checks++; if (bus.rd_data !== 8'hC3) begin errors++; $display("FAIL resume_data: got %h want c3", bus.rd_data); end
    bus.vid_rd_req = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b1;
    clear_inputs();
    test_reset();
    test_cpu_read();
    test_priority();
    test_dma_lock();
    test_starvation();
    test_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
